// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_pkg: shared FSM encoding, requester indices and burst constants for the cache bus arbiter
package cache_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  localparam int UNC = 0;
  localparam int DWB = 1;
  localparam int DRF = 2;
  localparam int IFR = 3;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  localparam logic [7:0] UNC_BURST_LEN = 8'd0;
  function automatic logic [7:0] line_burst_len(input int beats);
    return 8'(beats - 1);
  endfunction
  function automatic logic [1:0] pick(input logic [3:0] req, input logic promote);
    return req[UNC] ? 2'(UNC) :
           promote && req[IFR] ? 2'(IFR) :
           req[DWB] ? 2'(DWB) :
           req[DRF] ? 2'(DRF) : 2'(IFR);
  endfunction
endpackage

// File: rtl/cache_bus_arbiter_if.sv
// cache_bus_arbiter_if: requester and AXI-side signals of the cache bus arbiter
interface cache_bus_arbiter_if;
  logic [3:0] req;
  logic [127:0] req_addr;
  logic unc_rw;
  logic [31:0] unc_wdata;
  logic [31:0] dw_wdata;
  logic [3:0] grant;
  logic [3:0] beat;
  logic [3:0] done;
  logic [31:0] rd_data;
  logic bus_ar_en;
  logic bus_aw_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [7:0] bus_burst_len;
  logic bus_rd_ready;
  logic [31:0] bus_rd_data;
  logic bus_wr_ready;
  logic bus_wr_finish;
  modport master (
    input req, req_addr, unc_rw, unc_wdata, dw_wdata, bus_rd_ready, bus_rd_data, bus_wr_ready, bus_wr_finish,
    output grant, beat, done, rd_data, bus_ar_en, bus_aw_en, bus_addr, bus_wr_data, bus_burst_len
  );
  modport slave (
    output req, req_addr, unc_rw, unc_wdata, dw_wdata, bus_rd_ready, bus_rd_data, bus_wr_ready, bus_wr_finish,
    input grant, beat, done, rd_data, bus_ar_en, bus_aw_en, bus_addr, bus_wr_data, bus_burst_len
  );
endinterface

// File: rtl/cache_bus_arbiter_xlate.sv
// kseg_addr_xlate: strips the kseg0/kseg1 window so cached and uncached aliases hit the same physical address
module kseg_addr_xlate (
  input  logic [31:0] virt,
  output logic [31:0] phys
);
  assign phys = virt[31:29] == 3'b100 ? virt - 32'h8000_0000 :
                virt[31:29] == 3'b101 ? virt - 32'hA000_0000 : virt;
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: grants the single AXI port to one of four cache requesters and runs its burst
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int LINE_BEATS = 16
) (
  input logic clk,
  input logic reset,
  cache_bus_arbiter_if.master io
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state;
  logic [SW-1:0] starve;
  logic [4:0] cnt;
  logic wr;
  logic [1:0] win;
  logic [31:0] win_addr;
  logic [31:0] phys_addr;
  logic win_wr;
  logic rd_fin;
  assign win = pick(io.req, starve == SW'(STARVE_LIMIT));
  assign win_addr = io.req_addr[{win, 5'd0} +: 32];
  assign win_wr = win == 2'(DWB) || (win == 2'(UNC) && io.unc_rw == WRITE);
  assign rd_fin = io.bus_rd_ready && cnt == io.bus_burst_len[4:0];
  kseg_addr_xlate u_xlate (.virt(win_addr), .phys(phys_addr));
  // arbitration in IDLE latches the winner's transfer; ACTIVE counts beats until the burst completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve <= '0;
      cnt <= '0;
      wr <= READ;
      io.grant <= '0;
      io.bus_ar_en <= 1'b0;
      io.bus_aw_en <= 1'b0;
      io.bus_addr <= '0;
      io.bus_burst_len <= '0;
    end else begin
      case (state)
        IDLE: if (|io.req) begin
          state <= ACTIVE;
          io.grant <= 4'b1 << win;
          wr <= win_wr;
          io.bus_ar_en <= !win_wr;
          io.bus_aw_en <= win_wr;
          io.bus_addr <= phys_addr;
          io.bus_burst_len <= win == 2'(UNC) ? UNC_BURST_LEN : line_burst_len(LINE_BEATS);
          cnt <= '0;
          starve <= win == 2'(IFR) ? '0 :
                    io.req[IFR] && starve != SW'(STARVE_LIMIT) ? starve + 1'b1 : starve;
        end
        ACTIVE: begin
          if (io.bus_rd_ready) cnt <= cnt + 5'd1;
          if (wr ? io.bus_wr_finish : rd_fin) begin
            state <= DONE;
            io.bus_ar_en <= 1'b0;
            io.bus_aw_en <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          io.grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign io.beat = state == ACTIVE ? io.grant & {4{wr ? io.bus_wr_ready : io.bus_rd_ready}} : '0;
  assign io.done = state == DONE ? io.grant : '0;
  assign io.rd_data = io.bus_rd_ready ? io.bus_rd_data : '0;
  assign io.bus_wr_data = io.grant[UNC] && wr ? io.unc_wdata : io.grant[DWB] ? io.dw_wdata : '0;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: random requests and bus responses checked against a transaction-level reference model
module tb_cache_bus_arbiter;
  localparam int LIMIT = 8;
  localparam int BEATS = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cache_bus_arbiter_if bif();
  cache_bus_arbiter #(.STARVE_LIMIT(LIMIT), .LINE_BEATS(BEATS)) dut (
    .clk(clk),
    .reset(reset),
    .io(bif.master)
  );
  int n_chk = 0;
  int n_pass = 0;
  int owner = -1;
  int beats_left = 0;
  int starve = 0;
  bit done_ph = 1'b0;
  bit wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [7:0] m_len = '0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [31:0] xlate(input logic [31:0] a);
    case (a[31:28])
      4'h8, 4'h9: return a - 32'h8000_0000;
      4'hA, 4'hB: return a - 32'hA000_0000;
      default: return a;
    endcase
  endfunction
  function automatic int winner(input logic [3:0] r, input bit promote);
    int order[4];
    if (promote) order = '{0, 3, 1, 2};
    else order = '{0, 1, 2, 3};
    foreach (order[k]) if (r[order[k]]) return order[k];
    return -1;
  endfunction
  task automatic check_outputs();
    logic [3:0] g;
    bit act;
    g = owner >= 0 ? 4'(1 << owner) : 4'b0;
    act = owner >= 0 && !done_ph;
    check("grant", bif.grant, g);
    check("done", bif.done, done_ph ? g : 4'b0);
    check("beat", bif.beat, act ? g & {4{wr ? bif.bus_wr_ready : bif.bus_rd_ready}} : 4'b0);
    check("ar_en", bif.bus_ar_en, act && !wr);
    check("aw_en", bif.bus_aw_en, act && wr);
    check("bus_addr", bif.bus_addr, m_addr);
    check("burst_len", bif.bus_burst_len, m_len);
    check("rd_data", bif.rd_data, bif.bus_rd_ready ? bif.bus_rd_data : 32'h0);
    check("wr_data", bif.bus_wr_data, owner == 0 && wr ? bif.unc_wdata : owner == 1 ? bif.dw_wdata : 32'h0);
  endtask
  task automatic model_step();
    if (reset) begin
      owner = -1;
      done_ph = 1'b0;
      starve = 0;
      m_addr = '0;
      m_len = '0;
      return;
    end
    if (owner < 0) begin
      if (bif.req != 4'b0) begin
        owner = winner(bif.req, starve == LIMIT);
        wr = owner == 1 || (owner == 0 && bif.unc_rw);
        m_addr = xlate(bif.req_addr[32*owner +: 32]);
        m_len = owner == 0 ? 8'd0 : 8'(BEATS - 1);
        beats_left = int'(m_len) + 1;
        if (owner == 3) starve = 0;
        else if (bif.req[3] && starve < LIMIT) starve++;
      end
    end else if (!done_ph) begin
      if (wr) done_ph = bif.bus_wr_finish;
      else if (bif.bus_rd_ready) begin
        beats_left--;
        done_ph = beats_left == 0;
      end
    end else begin
      owner = -1;
      done_ph = 1'b0;
    end
  endtask
  task automatic drive(input logic [3:0] r, input bit rst);
    reset = rst;
    bif.req = r;
    for (int i = 0; i < 4; i++) bif.req_addr[32*i +: 32] = {4'($urandom_range(0, 15)), 28'($urandom)};
    bif.unc_rw = 1'($urandom_range(0, 1));
    bif.unc_wdata = $urandom;
    bif.dw_wdata = $urandom;
    bif.bus_rd_ready = $urandom_range(0, 9) < 6;
    bif.bus_rd_data = $urandom;
    bif.bus_wr_ready = 1'($urandom_range(0, 1));
    bif.bus_wr_finish = $urandom_range(0, 19) == 0;
  endtask
  initial begin
    bif.req = '0;
    bif.req_addr = '0;
    bif.unc_rw = 1'b0;
    bif.unc_wdata = '0;
    bif.dw_wdata = '0;
    bif.bus_rd_ready = 1'b0;
    bif.bus_rd_data = '0;
    bif.bus_wr_ready = 1'b0;
    bif.bus_wr_finish = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] r;
      @(negedge clk);
      r = c < 2000 ? 4'($urandom_range(0, 15)) :
          {2'b11, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0)};
      drive(r, c > 0 && $urandom_range(0, 249) == 0);
      #1;
      check_outputs();
      model_step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: lost arbitrations before ifetch is promoted.
REQ-002 The block SHALL have parameter LINE_BEATS, default 16: beats per cached line burst.
REQ-003 The block SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  in  4  request vector: bit0 uncache, bit1 dcache writeback, bit2 dcache refill, bit3 ifetch refill.
REQ-006 The block SHALL have port req_addr  in  128  per-requester address; slice [32i+31:32i] belongs to requester i.
REQ-007 The block SHALL have port unc_rw  in  1  uncache direction: 0 READ, 1 WRITE.
REQ-008 The block SHALL have port unc_wdata  in  32  uncache write data.
REQ-009 The block SHALL have port dw_wdata  in  32  writeback beat data.
REQ-010 The block SHALL have port grant  out  4  one-hot owner of the bus.
REQ-011 The block SHALL have port beat  out  4  per-requester beat strobe: read data valid, or write beat accepted.
REQ-012 The block SHALL have port done  out  4  per-requester one-cycle completion pulse.
REQ-013 The block SHALL have port rd_data  out  32  read beat data, shared by all requesters.
REQ-014 The block SHALL have port bus_ar_en  out  1  read burst enable to the AXI interface.
REQ-015 The block SHALL have port bus_aw_en  out  1  write burst enable to the AXI interface.
REQ-016 The block SHALL have port bus_addr  out  32  physical address, used for both read and write.
REQ-017 The block SHALL have port bus_wr_data  out  32  write beat data.
REQ-018 The block SHALL have port bus_burst_len  out  8  AXI len: LINE_BEATS-1 for cached transfers, 0 for uncache.
REQ-019 The block SHALL have port bus_rd_ready / bus_rd_data  in  1/32  read beat valid and data.
REQ-020 The block SHALL have port bus_wr_ready / bus_wr_finish  in  1/1  write beat accepted, and B-response complete.

Function
REQ-021 The FSM SHALL have states IDLE, ACTIVE and DONE; transitions IDLE->ACTIVE when any req bit is high, ACTIVE->DONE on completion, DONE->IDLE unconditionally.
REQ-022 In IDLE, arbitration SHALL use fixed priority uncache > writeback > refill > ifetch.
REQ-023 When the starvation counter equals STARVE_LIMIT, ifetch SHALL rank second, below uncache only.
REQ-024 Grant SHALL be registered: it is asserted the cycle after req is sampled in IDLE, and held through ACTIVE and DONE.
REQ-025 The winner's address and direction SHALL be latched at grant; later req changes, or req deassertion in ACTIVE, SHALL be ignored until DONE.
REQ-026 bus_ar_en SHALL equal ACTIVE and (refill, ifetch, or uncache READ); bus_aw_en SHALL equal ACTIVE and (writeback, or uncache WRITE).
REQ-027 The 5-bit beat counter SHALL increment on bus_rd_ready in ACTIVE; a read completes when bus_rd_ready arrives with count == bus_burst_len.
REQ-028 A write SHALL complete on bus_wr_finish.
REQ-029 beat[i] SHALL be grant[i] AND (bus_rd_ready for reads, bus_wr_ready for writes); done[i] SHALL be grant[i] AND DONE.
REQ-030 rd_data SHALL be bus_rd_data when bus_rd_ready is high, and 0 otherwise.
REQ-031 bus_wr_data SHALL mux unc_wdata or dw_wdata by owner, and be 0 when no write owner.
REQ-032 Address translation: 0x8/0x9 in [31:28] SHALL subtract 0x8000_0000; 0xA/0xB SHALL subtract 0xA000_0000; all other addresses pass unchanged.
REQ-033 The starvation counter SHALL increment, saturating at STARVE_LIMIT, when ifetch requests in IDLE and loses; it SHALL clear when ifetch is granted.
REQ-034 bus_rd_ready and bus_wr_ready SHALL be ignored in IDLE and DONE.
REQ-035 A requester still requesting in the IDLE cycle after DONE SHALL re-enter arbitration normally; there is no back-to-back grant without IDLE.

Reset
REQ-036 Reset SHALL force state IDLE, clear the beat and starvation counters, and zero grant, beat, done, bus_ar_en, bus_aw_en, bus_addr and bus_wr_data.
REQ-037 Reset asserted mid-burst SHALL abort with no done pulse.

Structure
REQ-038 Shared package cache_bus_pkg SHALL hold the state encoding, requester indices (UNC=0, DWB=1, DRF=2, IFR=3), READ/WRITE values and burst-length constants.
REQ-039 A single sub-module, kseg_addr_xlate, SHALL implement REQ-032.

Verification
REQ-040 req=4'b1100, ifetch addr 0x9FC0_0000 -> grant=4'b0100 first; after its 16th bus_rd_ready, done[2] pulses; then grant=4'b1000 with bus_addr=0x1FC0_0000.
REQ-041 Uncache read at 0xBFAF_8000 -> bus_ar_en high, bus_addr=0x1FAF_8000, bus_burst_len=0; one bus_rd_ready produces done[0] one cycle later.
REQ-042 req[3] held while refill is re-requested continuously -> ifetch granted after 8 lost arbitrations; a refill beat proceeds while uncache still preempts.
REQ-043 Writeback, 16 bus_wr_ready, then bus_wr_finish -> beat[1] pulses 16 times; done[1] follows bus_wr_finish by one cycle.
REQ-044 Reset asserted at beat 7 of a refill -> next cycle all outputs are 0 and the FSM is in IDLE; a new req is granted after reset is released.
REQ-045 Refill req dropped at beat 3 -> the burst still completes 16 beats and done[2] pulses.
